// File: rtl/ag_pkg.sv
// ag_pkg: shared constants for the address-generation stage latch and its
// register scoreboard (GPR count, counter width/limit, modrm field positions,
// decoded-field widths).
package ag_pkg;
    localparam int NUM_GPR   = 8;
    localparam int GPR_W     = 3;
    localparam int SB_CNT_W  = 2;
    localparam logic [SB_CNT_W-1:0] SB_MAX = 2'd3;

    // modrm layout: MOD [7:6], REG [5:3], RM [2:0]
    localparam int MOD_HI = 7;
    localparam int MOD_LO = 6;
    localparam int REG_HI = 5;
    localparam int REG_LO = 3;
    localparam int RM_HI  = 2;
    localparam int RM_LO  = 0;
    localparam logic [1:0] MOD_REG = 2'b11;

    localparam int ALUSEL_W = 2;
    localparam int JMP_W    = 3;
    localparam int MODRM_W  = 8;
    localparam int SEG_W    = 16;
    localparam int WORD_W   = 32;
endpackage

// File: rtl/ag_latch_reg_scoreboard.sv
// reg_scoreboard: one saturating pending-write counter per GPR.
//   i_src_a_v/i_src_a, i_src_b_v/i_src_b : candidate source GPRs from decode
//   i_dst_v/i_dst                        : candidate destination GPR
//   i_inc                                : stage capture this cycle (counts dst)
//   i_wb_v/i_wb_reg                      : writeback retiring one pending write
//   i_flush                              : clears all counters (not o_sb_err)
//   o_reg_dep                            : combinational dependency stall
//   o_sb_busy                            : any counter nonzero
//   o_sb_err                             : sticky writeback-to-empty-counter
module reg_scoreboard
    import ag_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_src_a_v,
    input  logic [GPR_W-1:0] i_src_a,
    input  logic             i_src_b_v,
    input  logic [GPR_W-1:0] i_src_b,
    input  logic             i_dst_v,
    input  logic [GPR_W-1:0] i_dst,
    input  logic             i_inc,
    input  logic             i_wb_v,
    input  logic [GPR_W-1:0] i_wb_reg,
    output logic             o_reg_dep,
    output logic             o_sb_busy,
    output logic             o_sb_err
);
    logic [NUM_GPR-1:0][SB_CNT_W-1:0] r_cnt;
    logic [NUM_GPR-1:0][SB_CNT_W-1:0] w_cnt_nxt;
    logic                             r_err;
    logic                             w_up;
    logic                             w_dn;
    logic                             w_underflow;

    // Saturated counters never wrap: a capture that ignores the stall simply
    // does not count past SB_MAX.
    assign w_up        = i_inc && i_dst_v && (r_cnt[i_dst] != SB_MAX);
    assign w_dn        = i_wb_v && (r_cnt[i_wb_reg] != '0);
    assign w_underflow = i_wb_v && (r_cnt[i_wb_reg] == '0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        for (int g = 0; g < NUM_GPR; g++) begin
            // Same-GPR increment and decrement cancel out.
            if (w_up && (i_dst == GPR_W'(g)) && !(w_dn && (i_wb_reg == GPR_W'(g))))
                w_cnt_nxt[g] = r_cnt[g] + SB_CNT_W'(1);
            else if (w_dn && (i_wb_reg == GPR_W'(g)) && !(w_up && (i_dst == GPR_W'(g))))
                w_cnt_nxt[g] = r_cnt[g] - SB_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= i_flush ? '0 : w_cnt_nxt;
            r_err <= r_err | w_underflow;
        end
    end

    assign o_reg_dep = (i_src_a_v && (r_cnt[i_src_a] != '0)) ||
                       (i_src_b_v && (r_cnt[i_src_b] != '0)) ||
                       (i_dst_v   && (r_cnt[i_dst] == SB_MAX));
    assign o_sb_busy = |r_cnt;
    assign o_sb_err  = r_err;
endmodule

// File: rtl/ag_latch.sv
// ag_latch: decode -> address-generation pipeline latch with a per-GPR
// pending-write scoreboard.
//   ld_ag/ag_vin : stage load enable / incoming valid
//   de_*         : decoded fields, registered into ag_* on a capture
//   flush        : kills ag_v and clears the scoreboard (priority over load)
//   wb_v/wb_reg  : writeback retiring one pending destination write
//   ag_v, ag_*   : registered stage contents
//   reg_dep      : combinational stall to decode (sources/dst saturation only)
//   sb_busy      : any write pending;  sb_err : sticky scoreboard underflow
module ag_latch
    import ag_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_ag,
    input  logic                ag_vin,
    input  logic                de_re,
    input  logic                de_we,
    input  logic                de_rmsel,
    input  logic                ro_needed,
    input  logic                rm_needed,
    input  logic [ALUSEL_W-1:0] de_alusel,
    input  logic [JMP_W-1:0]    de_jmp,
    input  logic [MODRM_W-1:0]  de_modrm,
    input  logic [SEG_W-1:0]    de_sreg,
    input  logic [SEG_W-1:0]    de_ptr,
    input  logic [WORD_W-1:0]   de_dval,
    input  logic [WORD_W-1:0]   de_sval,
    input  logic [WORD_W-1:0]   de_disp,
    input  logic [WORD_W-1:0]   de_flags,
    input  logic [WORD_W-1:0]   de_flag_ld,
    input  logic                flush,
    input  logic                wb_v,
    input  logic [GPR_W-1:0]    wb_reg,
    output logic                ag_v,
    output logic                ag_re,
    output logic                ag_we,
    output logic                ag_rmsel,
    output logic                ag_ro_needed,
    output logic                ag_rm_needed,
    output logic [ALUSEL_W-1:0] ag_alusel,
    output logic [JMP_W-1:0]    ag_jmp,
    output logic [MODRM_W-1:0]  ag_modrm,
    output logic [SEG_W-1:0]    ag_sreg,
    output logic [SEG_W-1:0]    ag_ptr,
    output logic [WORD_W-1:0]   ag_dval,
    output logic [WORD_W-1:0]   ag_sval,
    output logic [WORD_W-1:0]   ag_disp,
    output logic [WORD_W-1:0]   ag_flags,
    output logic [WORD_W-1:0]   ag_flag_ld,
    output logic                reg_dep,
    output logic                sb_busy,
    output logic                sb_err
);
    logic w_reg_mode;
    logic w_capture;

    // Register-direct addressing: RM names a GPR rather than a memory operand.
    assign w_reg_mode = (de_modrm[MOD_HI:MOD_LO] == MOD_REG);
    assign w_capture  = ld_ag && ag_vin && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ag_v         <= 1'b0;
            ag_re        <= 1'b0;
            ag_we        <= 1'b0;
            ag_rmsel     <= 1'b0;
            ag_ro_needed <= 1'b0;
            ag_rm_needed <= 1'b0;
            ag_alusel    <= '0;
            ag_jmp       <= '0;
            ag_modrm     <= '0;
            ag_sreg      <= '0;
            ag_ptr       <= '0;
            ag_dval      <= '0;
            ag_sval      <= '0;
            ag_disp      <= '0;
            ag_flags     <= '0;
            ag_flag_ld   <= '0;
        end else begin
            if (flush)      ag_v <= 1'b0;
            else if (ld_ag) ag_v <= ag_vin;
            if (w_capture) begin
                ag_re        <= de_re;
                ag_we        <= de_we;
                ag_rmsel     <= de_rmsel;
                ag_ro_needed <= ro_needed;
                ag_rm_needed <= rm_needed;
                ag_alusel    <= de_alusel;
                ag_jmp       <= de_jmp;
                ag_modrm     <= de_modrm;
                ag_sreg      <= de_sreg;
                ag_ptr       <= de_ptr;
                ag_dval      <= de_dval;
                ag_sval      <= de_sval;
                ag_disp      <= de_disp;
                ag_flags     <= de_flags;
                ag_flag_ld   <= de_flag_ld;
            end
        end
    end

    reg_scoreboard u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (flush),
        .i_src_a_v (ro_needed),
        .i_src_a   (de_modrm[REG_HI:REG_LO]),
        .i_src_b_v (rm_needed && w_reg_mode),
        .i_src_b   (de_modrm[RM_HI:RM_LO]),
        .i_dst_v   (de_we && w_reg_mode),
        .i_dst     (de_modrm[RM_HI:RM_LO]),
        .i_inc     (w_capture),
        .i_wb_v    (wb_v),
        .i_wb_reg  (wb_reg),
        .o_reg_dep (reg_dep),
        .o_sb_busy (sb_busy),
        .o_sb_err  (sb_err)
    );
endmodule
